// File: rtl/act_sram_reader.sv
// rtl/act_sram_reader.sv - activation SRAM read controller: credit-based read issue feeding a 4-entry output stream FIFO
// Optional feature macro: ACT_SRAM_READER_LANE_MASK_EN (per-lane zeroing of FIFO writes)
module act_sram_reader #(
    parameter int CH_NUM       = 4,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 12,
    parameter int DEPTH        = 18,
    parameter int AW           = 5
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [AW-1:0]                            base_addr,
    input  logic [AW-1:0]                            num_words,
`ifdef ACT_SRAM_READER_LANE_MASK_EN
    input  logic [CH_NUM*ACT_PER_ADDR-1:0]           lane_mask,
`endif
    output logic                                     busy,
    output logic                                     done,
    output logic                                     sram_csb,
    output logic                                     sram_wsb,
    output logic [AW-1:0]                            sram_raddr,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] out_data,
    output logic                                     out_last
);
    localparam int LANES = CH_NUM * ACT_PER_ADDR;
    localparam int DW    = LANES * BW_PER_ACT;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, num_q, cnt_q, raddr_q;
    logic          csb_q, done_q;
    logic          iss_q, iss_last_q, rv_q, rv_last_q;
    logic [DW-1:0] fifo_data_q [4];
    logic          fifo_last_q [4];
    logic [1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]    count_q;
    logic [3:0]    occupancy;
    logic          accept, issue, issue_last, push, pop;
    logic [DW-1:0] wdata;

    assign accept    = (state_q == S_IDLE) && start && (num_words != '0);
    // Credit covers both FIFO entries and reads still in the SRAM pipeline; a pop this cycle is not counted.
    assign occupancy = {1'b0, count_q} + {3'b0, iss_q} + {3'b0, rv_q};
    assign issue      = (state_q == S_RUN) && (occupancy < 4'd4);
    assign issue_last = issue && (cnt_q == num_q - AW'(1));
    assign push       = rv_q;
    assign pop        = out_valid && out_ready;

`ifdef ACT_SRAM_READER_LANE_MASK_EN
    logic [LANES-1:0] mask_q;

    always_comb begin
        wdata = sram_rdata;
        for (int l = 0; l < LANES; l++) begin
            if (mask_q[l]) begin
                wdata[l*BW_PER_ACT +: BW_PER_ACT] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= lane_mask;
        end
    end
`else
    assign wdata = sram_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (issue_last) state_d = S_DRAIN;
            S_DRAIN: if (pop && out_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = done_q;
        sram_csb   = csb_q;
        sram_wsb   = 1'b1;
        sram_raddr = raddr_q;
        out_valid  = (count_q != 3'd0);
        out_data   = out_valid ? fifo_data_q[rd_ptr_q] : '0;
        out_last   = out_valid && fifo_last_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            num_q      <= '0;
            cnt_q      <= '0;
            raddr_q    <= '0;
            csb_q      <= 1'b1;
            done_q     <= 1'b0;
            iss_q      <= 1'b0;
            iss_last_q <= 1'b0;
            rv_q       <= 1'b0;
            rv_last_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            done_q <= ((state_q == S_IDLE) && start && (num_words == '0)) ||
                      ((state_q == S_DRAIN) && pop && out_last);

            if (accept) begin
                addr_q <= base_addr;
                num_q  <= num_words;
                cnt_q  <= '0;
            end else if (issue) begin
                raddr_q <= addr_q;
                addr_q  <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
                cnt_q   <= cnt_q + AW'(1);
            end

            // Read pipeline: issue registered onto csb, data returns the following cycle.
            csb_q      <= ~issue;
            iss_q      <= issue;
            iss_last_q <= issue_last;
            rv_q       <= iss_q;
            rv_last_q  <= iss_last_q;

            if (push) begin
                fifo_data_q[wr_ptr_q] <= wdata;
                fifo_last_q[wr_ptr_q] <= rv_last_q;
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b0, push} - {2'b0, pop};
        end
    end
endmodule
